// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the program sequencer: state encoding and default widths.
package exec_sequencer_pkg;

  localparam int unsigned PcWDefault   = 4;
  localparam int unsigned DataWDefault = 11;

  typedef enum logic {
    StRun   = 1'b0,
    StSleep = 1'b1
  } seq_state_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// Decoder/memory-side signal bundle of the program sequencer.
interface exec_sequencer_if
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W   = PcWDefault,
  parameter int unsigned DATA_W = DataWDefault
);

  logic              en;
  logic [PC_W-1:0]   prog_last;
  logic              is_slp;
  logic              is_jmp;
  logic [DATA_W-1:0] slp_val;
  logic [PC_W-1:0]   jmp_tgt;
  logic              tick;
  logic [PC_W-1:0]   pc;
  logic              exec_en;
  logic              sleeping;
  logic [DATA_W-2:0] slp_cnt;

  modport master (
    input  en, prog_last, is_slp, is_jmp, slp_val, jmp_tgt, tick,
    output pc, exec_en, sleeping, slp_cnt
  );

  modport slave (
    output en, prog_last, is_slp, is_jmp, slp_val, jmp_tgt, tick,
    input  pc, exec_en, sleeping, slp_cnt
  );

endinterface

// File: rtl/exec_sequencer_sleep_counter.sv
// Remaining-sleep counter: loads a duration, counts ticks down, flags the final tick.
module exec_sequencer_sleep_counter #(
  parameter int unsigned CntW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            tick_i,
  output logic [CntW-1:0] cnt_o,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = tick_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/exec_sequencer.sv
// Program sequencer: owns the PC, retires one instruction per cycle, handles SLP/JMP.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W   = PcWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  exec_sequencer_if.master   bus
);

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   seq_pc, jmp_pc;
  logic              slp_take;
  logic              cnt_load, cnt_tick, cnt_done;
  logic [DATA_W-2:0] cnt;

  always_comb begin
    seq_pc   = (pc_q >= bus.prog_last) ? '0 : pc_q + 1'b1;
    jmp_pc   = (bus.jmp_tgt > bus.prog_last) ? '0 : bus.jmp_tgt;
    // Only strictly positive durations sleep; a JMP overrides a simultaneous SLP.
    slp_take = bus.is_slp && !bus.is_jmp && !bus.slp_val[DATA_W-1] && (bus.slp_val != '0);

    state_d  = state_q;
    pc_d     = pc_q;
    cnt_load = 1'b0;
    cnt_tick = 1'b0;

    if (bus.en) begin
      case (state_q)
        StRun: begin
          pc_d = bus.is_jmp ? jmp_pc : seq_pc;
          if (slp_take) begin
            cnt_load = 1'b1;
            state_d  = StSleep;
          end
        end
        StSleep: begin
          cnt_tick = bus.tick;
          if (cnt_done) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  exec_sequencer_sleep_counter #(
    .CntW (DATA_W - 1)
  ) u_sleep_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (bus.slp_val[DATA_W-2:0]),
    .tick_i     (cnt_tick),
    .cnt_o      (cnt),
    .done_o     (cnt_done)
  );

  assign bus.pc       = pc_q;
  assign bus.exec_en  = (state_q == StRun) && bus.en;
  assign bus.sleeping = (state_q == StSleep);
  assign bus.slp_cnt  = cnt;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_exec_sequencer;

  localparam int unsigned PC_W   = 4;
  localparam int unsigned DATA_W = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  exec_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: program line, whether asleep, ticks still owed.
  int m_pc     = 0;
  bit m_sleep  = 1'b0;
  int m_left   = 0;
  int cur_val  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_sleep = 1'b0;
    m_left  = 0;
  endtask

  task automatic model_step();
    int last, tgt;
    last = int'(bus.prog_last);
    tgt  = int'(bus.jmp_tgt);
    if (!bus.en) return;
    if (!m_sleep) begin
      if (bus.is_jmp) m_pc = (tgt > last) ? 0 : tgt;
      else            m_pc = (m_pc >= last) ? 0 : m_pc + 1;
      if (bus.is_slp && !bus.is_jmp && cur_val > 0) begin
        m_sleep = 1'b1;
        m_left  = cur_val;
      end
    end else if (bus.tick) begin
      m_left = m_left - 1;
      if (m_left == 0) m_sleep = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("pc",       32'(bus.pc),       32'(m_pc));
    chk("exec_en",  32'(bus.exec_en),  32'(!m_sleep && bus.en));
    chk("sleeping", 32'(bus.sleeping), 32'(m_sleep));
    chk("slp_cnt",  32'(bus.slp_cnt),  32'(m_left));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input int last, input bit s, input bit j, input int v,
                       input int tgt, input bit t);
    bus.en        = e;
    bus.prog_last = PC_W'(last);
    bus.is_slp    = s;
    bus.is_jmp    = j;
    cur_val       = v;
    bus.slp_val   = DATA_W'(v);
    bus.jmp_tgt   = PC_W'(tgt);
    bus.tick      = t;
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
  int held;
  int last_r;

  initial begin
    rst_n = 1'b0;
    drive(1, 3, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc",       32'(bus.pc),       32'd0);
    chk("rst_exec_en",  32'(bus.exec_en),  32'd1);
    chk("rst_sleeping", 32'(bus.sleeping), 32'd0);
    chk("rst_slp_cnt",  32'(bus.slp_cnt),  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Straight-line loop over four lines.
    for (int i = 0; i < 6; i++) begin
      chk("line_pc", 32'(bus.pc), 32'(exp_seq[i]));
      cyc();
    end

    // Jumps: in range, then out of range.
    for (int i = 0; i < 8 && m_pc != 0; i++) cyc();
    drive(1, 3, 0, 1, 0, 2, 0);
    cyc();
    chk("jmp_in_range", 32'(bus.pc), 32'd2);
    drive(1, 5, 0, 1, 0, 9, 0);
    cyc();
    chk("jmp_out_range", 32'(bus.pc), 32'd0);

    // SLP 3 at line 1, tick on the entry cycle ignored, then ticks every 4 clocks.
    drive(1, 5, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 5, 1, 0, 3, 0, 1);
    cyc();
    chk("slp_entry_sleep", 32'(bus.sleeping), 32'd1);
    chk("slp_entry_pc",    32'(bus.pc),       32'd2);
    chk("slp_entry_cnt",   32'(bus.slp_cnt),  32'd3);
    for (int k = 0; k < 12; k++) begin
      drive(1, 5, 0, 0, 0, 0, (k % 4) == 3);
      cyc();
    end
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("slp_wake_exec", 32'(bus.exec_en), 32'd1);
    chk("slp_wake_cnt",  32'(bus.slp_cnt), 32'd0);
    chk("slp_wake_pc",   32'(bus.pc),      32'd2);

    // Non-positive durations behave as NOP.
    drive(1, 5, 1, 0, 0, 0, 1);
    cyc();
    chk("slp_zero_pc",    32'(bus.pc),       32'd3);
    chk("slp_zero_sleep", 32'(bus.sleeping), 32'd0);
    drive(1, 5, 1, 0, -5, 0, 1);
    cyc();
    chk("slp_neg_pc",    32'(bus.pc),       32'd4);
    chk("slp_neg_sleep", 32'(bus.sleeping), 32'd0);

    // Freeze during SLEEP with ticks present, then wake on one-per-cycle ticks.
    drive(1, 5, 1, 0, 4, 0, 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(0, 5, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("freeze_slp_cnt", 32'(bus.slp_cnt), 32'd4);
    for (int k = 0; k < 5; k++) begin
      drive(1, 5, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("freeze_woke", 32'(bus.sleeping), 32'd0);

    // Freeze in RUN.
    held = int'(bus.pc);
    for (int k = 0; k < 3; k++) begin
      drive(0, 5, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("freeze_run_pc", 32'(bus.pc), 32'(held));

    // Lowering prog_last below pc wraps the next advance to 0.
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("lowered_last_pc", 32'(bus.pc), 32'd0);

    // Simultaneous SLP and JMP: the jump wins, no sleep.
    drive(1, 9, 1, 1, 5, 7, 0);
    cyc();
    chk("slp_jmp_pc",    32'(bus.pc),       32'd7);
    chk("slp_jmp_sleep", 32'(bus.sleeping), 32'd0);

    // Reset mid-sleep at line 4 with 7 units left.
    for (int i = 0; i < 20 && m_pc != 3; i++) begin
      drive(1, 9, 0, 0, 0, 0, 0);
      cyc();
    end
    drive(1, 9, 1, 0, 7, 0, 0);
    cyc();
    drive(1, 9, 0, 0, 0, 0, 0);
    cyc();
    chk("pre_rst_pc",  32'(bus.pc),      32'd4);
    chk("pre_rst_cnt", 32'(bus.slp_cnt), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc",    32'(bus.pc),       32'd0);
    chk("mid_rst_sleep", 32'(bus.sleeping), 32'd0);
    chk("mid_rst_cnt",   32'(bus.slp_cnt),  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("post_rst_pc", 32'(bus.pc), 32'd1);

    // Random traffic.
    last_r = 7;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) last_r = int'($urandom_range(0, 15));
      drive($urandom_range(0, 9) != 0, last_r,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 9)) - 3, int'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Program sequencer for the MCU core: owns the program counter, retires one instruction per cycle, and sequences the sleep and jump behaviour flagged by the instruction decoder. It sits between instruction memory and the decoder/register file, with `pc` addressing instruction memory. The decoder's `is_slp`/`is_jmp` flags and the operand-mux value steer it. `exec_en` gates every architectural side effect, including register write enable.

## Interface
- PC_W, 4, program-counter width (up to 16 lines)
- DATA_W, 11, signed operand width (values -999..999)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes all state
- prog_last  in  PC_W  index of last valid program line
- is_slp  in  1  decoder flag: current instruction is SLP
- is_jmp  in  1  decoder flag: current instruction is JMP
- slp_val  in  DATA_W  signed sleep duration in time units (register or immediate, already muxed)
- jmp_tgt  in  PC_W  jump target line
- tick  in  1  one-cycle time-unit pulse from the global timer
- pc  out  PC_W  address of the instruction being executed
- exec_en  out  1  the instruction at `pc` commits this cycle
- sleeping  out  1  high while in SLEEP
- slp_cnt  out  DATA_W-1  remaining time units (debug/observability)

## Operation
- Two states, RUN and SLEEP.
- Reset value of every output: `pc`=0, `exec_en`=1 if `en`, `sleeping`=0, `slp_cnt`=0. The state resets to RUN.
- `exec_en` = (state==RUN) && `en`. It is combinational.
- RUN with `en`=1 retires one instruction per cycle.
- Next-pc rule:
  - If `is_jmp`: pc ← (`jmp_tgt` > `prog_last`) ? 0 : `jmp_tgt`.
  - Otherwise: pc ← (pc ≥ `prog_last`) ? 0 : pc+1. Wrap-around is the normal program loop.
- `is_slp` with `slp_val` > 0:
  - pc advances per the next-pc rule, so SLP retires on entry.
  - `slp_cnt` ← `slp_val`[DATA_W-2:0].
  - State → SLEEP.
- `is_slp` with `slp_val` ≤ 0: no sleep; behaves as NOP (pc advances).
- `is_slp` and `is_jmp` both high: `is_jmp` wins and the sleep is ignored. The decoder never produces this; the rule must still hold.
- SLEEP:
  - `exec_en`=0 and `pc` holds.
  - Each `tick` decrements `slp_cnt`.
  - A `tick` with `slp_cnt`==1 sets `slp_cnt` to 0 and state → RUN.
  - The instruction at `pc` executes in the next cycle.
- A `tick` in RUN is ignored.
- `en`=0 in either state freezes `pc`, state and `slp_cnt`. Ticks are lost while `en`=0.
- `prog_last` lowered below the current `pc`: the next advance wraps to 0 (≥ compare). A jump still checks its target against the new `prog_last`.
- Reset asserted mid-sleep returns immediately to RUN, `pc`=0, `slp_cnt`=0.

## Timing
- RUN throughput: one instruction per clock, with zero-cycle decode-to-advance latency.
- Jump target is visible on `pc` one clock after the JMP cycle.
- SLP of N units:
  - `sleeping` rises the clock after the SLP cycle.
  - It falls the clock after the Nth tick.
  - The next instruction has `exec_en`=1 on that same clock.
- `tick` in the same cycle as SLP entry is not counted.
- Minimum sleep (N=1, tick every cycle) costs exactly one SLEEP cycle.
- All registers load on the rising edge of `clk`. `rst_n` clears them asynchronously and releases synchronously to the clock domain, via the system reset synchroniser.

## Structure
- Shared opcode header holds:
  - the state encoding constants (RUN=1'b0, SLEEP=1'b1);
  - PC_W/DATA_W defaults, alongside the existing opcode defines.
- One natural sub-module: `sleep_counter`. It loads, decrements on `tick`, and flags `done` when a tick arrives at count 1.
- `exec_sequencer` keeps the state register, next-pc logic and `exec_en`.

## Test plan
- Straight-line run, `prog_last`=3: `pc` sequence 0,1,2,3,0,1 on consecutive clocks, `exec_en`=1 throughout.
- JMP with `jmp_tgt`=2 at pc 0 → `pc`=2 next clock. JMP with `jmp_tgt`=9, `prog_last`=5 → `pc`=0.
- SLP with `slp_val`=3 at pc 1, ticks every 4 clocks:
  - `sleeping`=1 and `pc`=2 held, with `slp_cnt` stepping 3,2,1,0;
  - `exec_en`=1 resumes the clock after the third tick;
  - no register writes occur during SLEEP.
- SLP with `slp_val`=0 and with `slp_val`=-5 → no SLEEP entry, `pc` advances by 1.
- `en` low for 5 clocks during SLEEP with ticks present → `slp_cnt` unchanged. With `en` low in RUN → `pc` unchanged.
- `rst_n` pulsed low mid-sleep (`slp_cnt`=7, `pc`=4) → immediately `pc`=0, `sleeping`=0, `slp_cnt`=0, RUN resumes at line 0.
